// File: rtl/pq_pkg.sv
// Shared types and the ordering rule for the shift-register priority queue.
package pq_pkg;
   localparam int KEY_WIDTH = 8;
   localparam int VAL_WIDTH = 8;

   typedef struct packed {
      logic [KEY_WIDTH-1:0] key;
      logic [VAL_WIDTH-1:0] val;
   } kv_t;

   // Strict compare: equal keys never beat, which keeps equal keys in arrival order.
   function automatic logic beats(kv_t a, kv_t b, bit min_first);
      return min_first ? (a.key < b.key) : (a.key > b.key);
   endfunction
endpackage

// File: rtl/sr_pq_cell.sv
// One queue slot: holds an entry and its valid bit, and picks its next value
// from itself, its neighbours and the incoming entry.
module sr_pq_cell
   import pq_pkg::*;
#(
   parameter int KW        = KEY_WIDTH,
   parameter int VW        = VAL_WIDTH,
   parameter bit MIN_FIRST = 1'b1,
   parameter bit HEAD      = 1'b0
) (
   input  logic            clk,
   input  logic            clr_i,
   input  logic [KW+VW-1:0] left_data_i,
   input  logic            left_valid_i,
   input  logic [KW+VW-1:0] right_data_i,
   input  logic            right_valid_i,
   input  logic [KW+VW-1:0] new_data_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic            left_nb_i,
   output logic [KW+VW-1:0] data_o,
   output logic            valid_o,
   output logic            nb_o
);
   logic [KW+VW-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             right_nb;

   function automatic logic key_beats(logic [KW-1:0] a, logic [KW-1:0] b);
      return MIN_FIRST ? (a < b) : (a > b);
   endfunction

   assign nb_o     = !valid_q || key_beats(new_data_i[KW+VW-1:VW], data_q[KW+VW-1:VW]);
   assign right_nb = !right_valid_i ||
                     key_beats(new_data_i[KW+VW-1:VW], right_data_i[KW+VW-1:VW]);

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (push_i && pop_i) begin
         // Head leaves: cells below the insertion point keep their entry,
         // the slot just above it takes the new one, the rest shift up.
         if (!HEAD && nb_o) begin
            data_d  = data_q;
            valid_d = valid_q;
         end else if (right_nb) begin
            data_d  = new_data_i;
            valid_d = 1'b1;
         end else begin
            data_d  = right_data_i;
            valid_d = right_valid_i;
         end
      end else if (push_i) begin
         if (left_nb_i) begin
            data_d  = left_data_i;
            valid_d = left_valid_i;
         end else if (nb_o) begin
            data_d  = new_data_i;
            valid_d = 1'b1;
         end
      end else if (pop_i) begin
         data_d  = right_data_i;
         valid_d = right_valid_i;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
endmodule

// File: rtl/sr_pq_param.sv
// Parametrised shift-register priority queue with valid/ready push and pop,
// flush and occupancy count; the head entry is always on odata.
module sr_pq_param
   import pq_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
   parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
   parameter bit MIN_FIRST = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0] idata,
   input  logic                          ivalid,
   output logic                          irdy,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0] odata,
   output logic                          ovalid,
   input  logic                          ordy,
   input  logic                          flush,
   output logic [$clog2(DEPTH+1)-1:0]    count
);
   localparam int W  = KEY_WIDTH + VAL_WIDTH;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  cell_data  [DEPTH];
   logic          cell_valid [DEPTH];
   logic          cell_nb    [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic          push, pop, clr;

   assign clr    = rst || flush;
   assign ovalid = cell_valid[0] && !flush;
   assign irdy   = !rst && !flush && ((count_q < CW'(DEPTH)) || ordy);
   assign push   = ivalid && irdy;
   assign pop    = ordy && ovalid;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
         logic [W-1:0] left_data, right_data;
         logic         left_valid, right_valid, left_nb;
         if (gi == 0) begin : g_head
            assign left_data  = '0;
            assign left_valid = 1'b0;
            assign left_nb    = 1'b0;
         end else begin : g_body
            assign left_data  = cell_data[gi-1];
            assign left_valid = cell_valid[gi-1];
            assign left_nb    = cell_nb[gi-1];
         end
         if (gi == DEPTH-1) begin : g_tail
            assign right_data  = '0;
            assign right_valid = 1'b0;
         end else begin : g_mid
            assign right_data  = cell_data[gi+1];
            assign right_valid = cell_valid[gi+1];
         end
         sr_pq_cell #(
            .KW(KEY_WIDTH), .VW(VAL_WIDTH), .MIN_FIRST(MIN_FIRST), .HEAD(gi == 0)
         ) u_cell (
            .clk(clk), .clr_i(clr),
            .left_data_i(left_data), .left_valid_i(left_valid),
            .right_data_i(right_data), .right_valid_i(right_valid),
            .new_data_i(idata), .push_i(push), .pop_i(pop), .left_nb_i(left_nb),
            .data_o(cell_data[gi]), .valid_o(cell_valid[gi]), .nb_o(cell_nb[gi])
         );
      end
   endgenerate

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (clr) count_q <= '0;
      else     count_q <= count_d;
   end

   assign odata = cell_data[0];
   assign count = count_q;
endmodule
